// File: rtl/fft_mag_stage.sv
// fft_mag_stage
//   Reads the lower half (bins 0..N/2-1) of the FFT result RAM after the FFT
//   reports completion. It computes re^2 + im^2 for each bin, then scales and
//   saturates the value and writes it into the spectrum buffer. It handshakes
//   with the FFT (result release) and with the display side (frame done/ack).
//
//   Optional feature: define FFT_MAG_LOG_EN to replace the linear
//   shift/saturate output with an approximate log2 output. That build adds one
//   extra pipeline stage.
//
// Ports
//   clk, rst_n        system clock, asynchronous active-low reset
//   fft_done_i        one-cycle pulse: FFT results are valid
//   fft_addr_o        read address into the FFT result RAM
//   fft_real_i/img_i  signed result data, valid RAM_LAT cycles after the address
//   fft_release_o     one-cycle pulse: results consumed, FFT may overwrite RAM
//   bin_addr_o/data_o spectrum buffer write address / data
//   bin_we_o          spectrum buffer write enable
//   frame_done_o      one-cycle pulse together with the last bin write
//   frame_ack_i       display has taken the frame (looked at only in WAIT_ACK)
//   busy_o            high whenever the FSM is not IDLE
//   overrun_o         sticky: an fft_done_i event was dropped
//
// Handshakes: all pulses are single-cycle, active-high, and sampled on the
// rising clock edge. No backpressure exists. The RAM is read at one address
// per cycle, and every write leaves the pipeline on contiguous cycles.
module fft_mag_stage #(
    parameter int N_POINTS   = 1024,
    parameter int DATA_WIDTH = 32,
    parameter int OUT_WIDTH  = 16,
    parameter int MAG_SHIFT  = 40,
    parameter int RAM_LAT    = 2,
    localparam int ADDR_WIDTH = $clog2(N_POINTS)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         fft_done_i,
    output logic [ADDR_WIDTH-1:0]        fft_addr_o,
    input  logic signed [DATA_WIDTH-1:0] fft_real_i,
    input  logic signed [DATA_WIDTH-1:0] fft_img_i,
    output logic                         fft_release_o,
    output logic [ADDR_WIDTH-2:0]        bin_addr_o,
    output logic [OUT_WIDTH-1:0]         bin_data_o,
    output logic                         bin_we_o,
    output logic                         frame_done_o,
    input  logic                         frame_ack_i,
    output logic                         busy_o,
    output logic                         overrun_o
);

    localparam int BIN_W = ADDR_WIDTH - 1;
    localparam int SQ_W  = 2 * DATA_WIDTH;
    localparam int SUM_W = SQ_W + 1;
    localparam logic [BIN_W-1:0] LAST_BIN = '1;

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_READ     = 2'd1;
    localparam logic [1:0] S_DRAIN    = 2'd2;
    localparam logic [1:0] S_WAIT_ACK = 2'd3;

    logic [1:0]            state_q, state_d;
    logic                  pending_q, pending_d;
    logic                  overrun_q, overrun_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  issue;

    logic                  bin_we_q;
    logic [BIN_W-1:0]      bin_addr_q;
    logic [OUT_WIDTH-1:0]  bin_data_q;

    // ------------------------------------------------------------------ FSM
    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        overrun_d = overrun_q;
        addr_d    = addr_q;
        issue     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (fft_done_i || pending_q) begin
                    state_d   = S_READ;
                    addr_d    = '0;
                    pending_d = 1'b0;
                    // A fresh pulse while a pending one is being serviced is a
                    // second event that cannot be queued.
                    if (fft_done_i && pending_q) overrun_d = 1'b1;
                end
            end
            S_READ: begin
                issue = 1'b1;
                if (addr_q[BIN_W-1:0] == LAST_BIN) state_d = S_DRAIN;
                else                               addr_d  = addr_q + ADDR_WIDTH'(1);
            end
            S_DRAIN: begin
                // Leave in the same cycle that the last write is presented.
                if (frame_done_o) state_d = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                if (frame_ack_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // A completion pulse during a frame is remembered once. A further
        // pulse is dropped and flagged. This includes the WAIT_ACK exit cycle.
        if (state_q != S_IDLE && fft_done_i) begin
            if (pending_q) overrun_d = 1'b1;
            else           pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            pending_q <= 1'b0;
            overrun_q <= 1'b0;
            addr_q    <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
            addr_q    <= addr_d;
        end
    end

    // ------------------------------------------------ RAM latency alignment
    // Valid and bin address travel alongside the RAM read. After RAM_LAT
    // cycles the tail entry lines up with fft_real_i/fft_img_i.
    logic [RAM_LAT-1:0] lat_v_q;
    logic [BIN_W-1:0]   lat_a_q [RAM_LAT];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_v_q <= '0;
            for (int i = 0; i < RAM_LAT; i++) lat_a_q[i] <= '0;
        end else begin
            lat_v_q[0] <= issue;
            lat_a_q[0] <= addr_q[BIN_W-1:0];
            for (int i = 1; i < RAM_LAT; i++) begin
                lat_v_q[i] <= lat_v_q[i-1];
                lat_a_q[i] <= lat_a_q[i-1];
            end
        end
    end

    // ------------------------------------------------------- S1: squaring
    // Operands are sign-extended to full product width first, so that
    // (-2^(DATA_WIDTH-1))^2 is exact.
    logic signed [SQ_W-1:0] re_ext, im_ext, re_sq_s, im_sq_s;
    logic [SQ_W-1:0]        re_sq_q, im_sq_q;
    logic                   s1_v_q;
    logic [BIN_W-1:0]       s1_a_q;
    logic [SUM_W-1:0]       sum_w;

    assign re_ext  = SQ_W'(fft_real_i);
    assign im_ext  = SQ_W'(fft_img_i);
    assign re_sq_s = re_ext * re_ext;
    assign im_sq_s = im_ext * im_ext;
    assign sum_w   = {1'b0, re_sq_q} + {1'b0, im_sq_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v_q  <= 1'b0;
            s1_a_q  <= '0;
            re_sq_q <= '0;
            im_sq_q <= '0;
        end else begin
            s1_v_q  <= lat_v_q[RAM_LAT-1];
            s1_a_q  <= lat_a_q[RAM_LAT-1];
            re_sq_q <= $unsigned(re_sq_s);
            im_sq_q <= $unsigned(im_sq_s);
        end
    end

`ifdef FFT_MAG_LOG_EN
    // ------------------------------------- S2: sum register, S3: log2 approx
    localparam int P_W    = $clog2(SUM_W);
    localparam int UP_W   = OUT_WIDTH - 9;
    localparam int UP_MAX = (1 << UP_W) - 1;

    logic             s2_v_q;
    logic [BIN_W-1:0] s2_a_q;
    logic [SUM_W-1:0] s2_sum_q;
    logic [P_W-1:0]   lead_idx;
    logic [SUM_W-1:0] norm;
    logic [8:0]       frac;
    logic [UP_W-1:0]  up;
    logic [OUT_WIDTH-1:0] log_val;

    always_comb begin
        lead_idx = '0;
        for (int i = 0; i < SUM_W; i++) begin
            if (s2_sum_q[i]) lead_idx = i[P_W-1:0];
        end
        // Normalise the leading one to the MSB. The 9 bits below it are the
        // fraction, zero-filled when fewer than 9 bits exist.
        norm    = s2_sum_q << (P_W'(SUM_W - 1) - lead_idx);
        frac    = norm[SUM_W-2 -: 9];
        up      = (int'(lead_idx) > UP_MAX) ? '1 : UP_W'(lead_idx);
        log_val = (s2_sum_q == '0) ? '0 : {up, frac};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_v_q     <= 1'b0;
            s2_a_q     <= '0;
            s2_sum_q   <= '0;
            bin_we_q   <= 1'b0;
            bin_addr_q <= '0;
            bin_data_q <= '0;
        end else begin
            s2_v_q   <= s1_v_q;
            s2_a_q   <= s1_a_q;
            s2_sum_q <= sum_w;
            bin_we_q <= s2_v_q;
            if (s2_v_q) begin
                bin_addr_q <= s2_a_q;
                bin_data_q <= log_val;
            end
        end
    end
`else
    // --------------------------------------- S2: shift, saturate, write out
    logic [SUM_W-1:0]     shifted;
    logic [OUT_WIDTH-1:0] lin_val;

    assign shifted = sum_w >> MAG_SHIFT;
    assign lin_val = (|shifted[SUM_W-1:OUT_WIDTH]) ? '1 : shifted[OUT_WIDTH-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_we_q   <= 1'b0;
            bin_addr_q <= '0;
            bin_data_q <= '0;
        end else begin
            bin_we_q <= s1_v_q;
            if (s1_v_q) begin
                bin_addr_q <= s1_a_q;
                bin_data_q <= lin_val;
            end
        end
    end
`endif

    // -------------------------------------------------------------- outputs
    // A write enable only occurs inside a frame. Therefore the last bin
    // address with write enable set marks the end of the frame exactly.
    assign frame_done_o  = bin_we_q && (bin_addr_q == LAST_BIN);
    assign fft_release_o = frame_done_o;
    assign fft_addr_o    = addr_q;
    assign bin_we_o      = bin_we_q;
    assign bin_addr_o    = bin_addr_q;
    assign bin_data_o    = bin_data_q;
    assign busy_o        = (state_q != S_IDLE);
    assign overrun_o     = overrun_q;

endmodule

// File: tb/tb_fft_mag_stage.sv
// Testbench for fft_mag_stage. Two instances share one RAM model: one has
// MAG_SHIFT=0 and one has MAG_SHIFT=8. Expected writes are pushed into one
// queue per instance when a frame is requested. A negedge monitor pops an
// entry and compares it on every bin write.
module tb_fft_mag_stage;

    localparam int N  = 16;
    localparam int AW = 4;
    localparam int BW = 3;
    localparam int DW = 32;
    localparam int OW = 16;
    localparam int RL = 2;
`ifdef FFT_MAG_LOG_EN
    localparam int LAT = 6;
`else
    localparam int LAT = 5;
`endif

    // ------------------------------------------------ clock / reset block
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic                 fft_done  = 1'b0;
    logic                 frame_ack = 1'b0;
    logic signed [DW-1:0] fft_real, fft_img;

    logic [AW-1:0] addr0, addr8;
    logic [BW-1:0] baddr0, baddr8;
    logic [OW-1:0] bdata0, bdata8;
    logic          rel0, rel8, we0, we8, fd0, fd8, busy0, busy8, ovr0, ovr8;

    fft_mag_stage #(.N_POINTS(N), .DATA_WIDTH(DW), .OUT_WIDTH(OW),
                    .MAG_SHIFT(0), .RAM_LAT(RL)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .fft_done_i(fft_done), .fft_addr_o(addr0),
        .fft_real_i(fft_real), .fft_img_i(fft_img), .fft_release_o(rel0),
        .bin_addr_o(baddr0), .bin_data_o(bdata0), .bin_we_o(we0),
        .frame_done_o(fd0), .frame_ack_i(frame_ack), .busy_o(busy0),
        .overrun_o(ovr0));

    fft_mag_stage #(.N_POINTS(N), .DATA_WIDTH(DW), .OUT_WIDTH(OW),
                    .MAG_SHIFT(8), .RAM_LAT(RL)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .fft_done_i(fft_done), .fft_addr_o(addr8),
        .fft_real_i(fft_real), .fft_img_i(fft_img), .fft_release_o(rel8),
        .bin_addr_o(baddr8), .bin_data_o(bdata8), .bin_we_o(we8),
        .frame_done_o(fd8), .frame_ack_i(frame_ack), .busy_o(busy8),
        .overrun_o(ovr8));

    // ------------------------------------------- FFT result RAM, latency 2
    logic signed [DW-1:0] mem_re [N];
    logic signed [DW-1:0] mem_im [N];
    logic signed [DW-1:0] rd_re1, rd_im1;
    always @(posedge clk) begin
        rd_re1   <= mem_re[addr0];
        rd_im1   <= mem_im[addr0];
        fft_real <= rd_re1;
        fft_img  <= rd_im1;
    end

    // ------------------------------------------------- directed vectors
    // Frame A: re = k, im = 0. Frame B: hand-picked corner values.
    logic signed [DW-1:0] b_re [8] = '{32'sd3, 32'sh8000_0000, 32'sh1000, 32'sd142,
                                       32'sh100, -32'sd300, -32'sd4000, 32'sd4095};
    logic signed [DW-1:0] b_im [8] = '{32'sd4, 32'sh8000_0000, 32'sd0, 32'sd213,
                                       32'sd0, 32'sd200, 32'sd0, 32'sd90};
`ifdef FFT_MAG_LOG_EN
    logic [OW-1:0] a_exp0 [8] = '{16'd0, 16'd0, 16'd1024, 16'd1600, 16'd2048, 16'd2336, 16'd2624, 16'd2832};
    logic [OW-1:0] a_exp8 [8] = '{16'd0, 16'd0, 16'd1024, 16'd1600, 16'd2048, 16'd2336, 16'd2624, 16'd2832};
    logic [OW-1:0] b_exp0 [8] = '{16'd2336, 16'd32256, 16'd12288, 16'd8191, 16'd8192, 16'd8695, 16'd12240, 16'd12287};
    logic [OW-1:0] b_exp8 [8] = '{16'd2336, 16'd32256, 16'd12288, 16'd8191, 16'd8192, 16'd8695, 16'd12240, 16'd12287};
`else
    logic [OW-1:0] a_exp0 [8] = '{16'd0, 16'd1, 16'd4, 16'd9, 16'd16, 16'd25, 16'd36, 16'd49};
    logic [OW-1:0] a_exp8 [8] = '{16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
    logic [OW-1:0] b_exp0 [8] = '{16'd25, 16'hFFFF, 16'hFFFF, 16'hFFFD, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
    logic [OW-1:0] b_exp8 [8] = '{16'd0, 16'hFFFF, 16'hFFFF, 16'd255, 16'd256, 16'd507, 16'd62500, 16'hFFFF};
`endif

    // --------------------------------------------------------- scoreboard
    logic [BW+OW-1:0] exp0_q[$];
    logic [BW+OW-1:0] exp8_q[$];
    int n_chk       = 0;
    int n_err       = 0;
    int frames_seen = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic mon_port(input int id, input logic we, input logic [BW-1:0] ba,
                            input logic [OW-1:0] bd, input logic fd, input logic rel);
        logic [BW+OW-1:0] e;
        if (we) begin
            if ((id == 0 && exp0_q.size() == 0) || (id == 8 && exp8_q.size() == 0)) begin
                n_chk++;
                n_err++;
                $display("FAIL unexpected_write dut%0d: got addr=%0d data=%0h expected no write", id, ba, bd);
            end else begin
                if (id == 0) e = exp0_q.pop_front();
                else         e = exp8_q.pop_front();
                check($sformatf("bin_write_dut%0d", id), {ba, bd}, e);
                check($sformatf("frame_end_dut%0d", id), {fd, rel}, {2{e[BW+OW-1 -: BW] == 3'd7}});
            end
        end else if (fd || rel) begin
            check($sformatf("pulse_without_write_dut%0d", id), {fd, rel}, 2'b00);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            mon_port(0, we0, baddr0, bdata0, fd0, rel0);
            mon_port(8, we8, baddr8, bdata8, fd8, rel8);
            if (we0 && fd0) frames_seen++;
        end
    end

    // ------------------------------------------------------ driver tasks
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic load_frame(input bit is_b);
        for (int k = 0; k < N; k++) begin
            mem_re[k] = (is_b && k < 8) ? b_re[k] : DW'(k);
            mem_im[k] = (is_b && k < 8) ? b_im[k] : '0;
        end
    endtask

    task automatic push_frame(input bit is_b);
        for (int k = 0; k < 8; k++) begin
            exp0_q.push_back({BW'(k), is_b ? b_exp0[k] : a_exp0[k]});
            exp8_q.push_back({BW'(k), is_b ? b_exp8[k] : a_exp8[k]});
        end
    endtask

    task automatic pulse_done();
        fft_done = 1'b1;
        tick();
        fft_done = 1'b0;
    endtask

    task automatic pulse_ack();
        frame_ack = 1'b1;
        tick();
        frame_ack = 1'b0;
    endtask

    // Waits for the first write and checks its distance from cycle c0.
    task automatic wait_first_write(input int c0, input int lat, input string name);
        for (int i = 0; i < 30 && !we0; i++) tick();
        check(name, we0 ? 64'(cyc - c0) : 64'hDEAD, 64'(lat));
    endtask

    task automatic start_frame(input bit is_b);
        int c0;
        push_frame(is_b);
        c0 = cyc;
        pulse_done();
        wait_first_write(c0, LAT, "first_write_latency");
    endtask

    task automatic wait_frames(input int target);
        for (int i = 0; i < 200 && frames_seen < target; i++) tick();
        check("frame_done_count_reached", 64'(frames_seen >= target), 64'd1);
    endtask

    // ------------------------------------------------------------ stimulus
    initial begin : stim
        int c0;
        load_frame(1'b0);
        repeat (3) tick();
        check("reset_outputs_dut0", {addr0, rel0, baddr0, bdata0, we0, fd0, busy0, ovr0}, 64'd0);
        check("reset_outputs_dut8", {addr8, rel8, baddr8, bdata8, we8, fd8, busy8, ovr8}, 64'd0);
        rst_n = 1'b1;
        repeat (2) tick();

        // Frame A: k^2 values and first-write latency.
        start_frame(1'b0);
        wait_frames(1);
        repeat (3) tick();
        check("busy_in_wait_ack", busy0, 1'b1);
        pulse_ack();
        check("ack_returns_idle", busy0, 1'b0);
        repeat (2) tick();

        // Frame B: corner values. Ack during READ is ignored. A second done
        // during READ becomes pending.
        load_frame(1'b1);
        start_frame(1'b1);
        pulse_ack();
        push_frame(1'b1);
        pulse_done();
        wait_frames(2);
        repeat (3) tick();
        check("early_ack_ignored", busy0, 1'b1);
        check("single_pending_no_overrun", ovr0, 1'b0);
        pulse_done();
        tick();
        check("overrun_on_third_done", ovr0, 1'b1);

        c0 = cyc;
        pulse_ack();
        check("idle_before_pending_frame", busy0, 1'b0);
        wait_first_write(c0, LAT + 1, "pending_restart_latency");
        wait_frames(3);
        tick();
        check("overrun_sticky_dut0", ovr0, 1'b1);
        check("overrun_sticky_dut8", ovr8, 1'b1);
        pulse_ack();
        repeat (2) tick();

        // Reset in the middle of READ, then restart from address 0.
        load_frame(1'b0);
        push_frame(1'b0);
        pulse_done();
        for (int i = 0; i < 20 && addr0 != 4'd3; i++) tick();
        check("reached_addr3", addr0, 4'd3);
        rst_n = 1'b0;
        #1;
        check("midframe_reset_dut0", {addr0, rel0, baddr0, bdata0, we0, fd0, busy0, ovr0}, 64'd0);
        check("midframe_reset_dut8", {addr8, rel8, baddr8, bdata8, we8, fd8, busy8, ovr8}, 64'd0);
        exp0_q.delete();
        exp8_q.delete();
        tick();
        rst_n = 1'b1;
        tick();
        start_frame(1'b0);
        wait_frames(4);
        pulse_ack();
        repeat (6) tick();

        check("scoreboard_empty_dut0", 64'(exp0_q.size()), 64'd0);
        check("scoreboard_empty_dut8", 64'(exp8_q.size()), 64'd0);
        check("total_frames", 64'(frames_seen), 64'd4);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/fft_mag_stage.md
Name: fft_mag_stage

Overview:
- Downstream neighbour of the FFT block in the spectrum analyzer.
- After the FFT signals completion, this block reads the complex result RAM for bins 0..N/2-1 and computes squared magnitude (re²+im²).
- It scales and saturates each value and writes it into the display/spectrum buffer.
- It handshakes with the FFT (result release) and with the display side (frame done/ack).

Parameters:
- N_POINTS, 1024: FFT length, power of 2, >=8.
- DATA_WIDTH, 32: signed width of the FFT real/imag components.
- OUT_WIDTH, 16: unsigned width of the output bin value.
- MAG_SHIFT, 40: right shift applied to the (2*DATA_WIDTH+1)-bit sum before saturation.
- RAM_LAT, 2: FFT result RAM read latency in cycles, 1..4.
- ADDR_WIDTH, $clog2(N_POINTS): derived, not overridden.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- fft_done_i  in  1  one-cycle pulse: FFT results valid (driven by FFT end_o).
- fft_addr_o  out  ADDR_WIDTH  read address into FFT result RAM.
- fft_real_i  in  DATA_WIDTH  signed real part, valid RAM_LAT cycles after address.
- fft_img_i  in  DATA_WIDTH  signed imaginary part, same timing.
- fft_release_o  out  1  one-cycle pulse: results consumed, FFT may overwrite RAM.
- bin_addr_o  out  ADDR_WIDTH-1  spectrum buffer write address.
- bin_data_o  out  OUT_WIDTH  spectrum buffer write data.
- bin_we_o  out  1  spectrum buffer write enable.
- frame_done_o  out  1  one-cycle pulse: last bin of frame written.
- frame_ack_i  in  1  display side has taken the frame; sampled only in WAIT_ACK.
- busy_o  out  1  high in any state except IDLE.
- overrun_o  out  1  sticky flag: fft_done_i lost; cleared only by reset.

Behaviour:
- Reset (async, rst_n=0): all outputs are 0, the state is IDLE, the pending flag is cleared, and the pipeline valid bits are cleared.
- A reset mid-frame aborts the frame with no release and no frame_done.
- States:
  - IDLE: if fft_done_i or pending -> READ. fft_addr_o<=0, pending cleared.
  - READ: issues addresses 0..N/2-1, one per cycle, no stalls. After issuing N/2-1 -> DRAIN.
  - DRAIN: waits until the pipeline is empty (last write done). In the cycle of the last bin_we_o, frame_done_o=1 and fft_release_o=1 -> WAIT_ACK.
  - WAIT_ACK: frame_ack_i=1 -> IDLE. Otherwise stay.
- Pipeline, linear mode:
  - Address at cycle t; data captured at t+RAM_LAT.
  - Stage S1 (t+RAM_LAT+1): registers re² and im² (unsigned, 2*DATA_WIDTH bits each).
  - Stage S2 (t+RAM_LAT+2): sum (2*DATA_WIDTH+1 bits) >> MAG_SHIFT, saturated to 2^OUT_WIDTH-1. bin_we_o=1 with bin_addr_o=t's address.
  - Address-to-write latency is RAM_LAT+2. The write address travels with the valid bit through the pipeline.
- Arithmetic: -2^(DATA_WIDTH-1) squared must be exact; no truncation before the shift. Rounding is truncation.
- Writes: exactly N/2 writes per frame, addresses strictly increasing 0..N/2-1, contiguous cycles. bin_we_o is never asserted outside a frame.
- fft_done_i handling:
  - In IDLE: starts a frame.
  - In READ/DRAIN/WAIT_ACK: sets pending. If pending is already set, overrun_o<=1 and the event is dropped.
  - Coincident with the exit of WAIT_ACK: sets pending, which is serviced on the next IDLE cycle.
- frame_ack_i outside WAIT_ACK is ignored; it is not remembered.
- fft_addr_o holds its last value outside READ.

Optional Feature:
- Macro: FFT_MAG_LOG_EN.
- Defined: S2 output goes to an extra stage S3, so latency is RAM_LAT+3.
  - S3 computes an approximate log2 of the unshifted sum: p = index of the leading one (0..2*DATA_WIDTH).
  - Output is {p in the upper OUT_WIDTH-9 bits, saturated; next 9 bits below the leading one, zero-padded, in the lower 9 bits}.
  - A sum of 0 outputs 0. MAG_SHIFT and linear saturation are unused.
- Undefined: linear shifted/saturated output only; no S3 logic is present.

Test Plan:
- N_POINTS=16, RAM_LAT=2, MAG_SHIFT=0, RAM holds re=k, im=0 at addr k. Pulse fft_done_i -> 8 writes addr 0..7, data k², first bin_we_o 4 cycles after the first address. frame_done_o and fft_release_o fire with write 7.
- re=im=-2^31, MAG_SHIFT=40 -> sum 2^63, shifted 2^23, saturated -> bin_data_o=16'hFFFF.
- re=3, im=4, MAG_SHIFT=0 -> bin_data_o=25. re=0x1000, im=0, MAG_SHIFT=8 -> 0x10000 saturates to 0xFFFF.
- Second fft_done_i during READ -> pending; after frame_ack_i a new frame starts one cycle after IDLE. A third pulse while pending -> overrun_o=1 stays set.
- rst_n low for 1 cycle mid-READ (addr 3) -> all outputs 0 immediately, no frame_done_o. A new fft_done_i restarts at addr 0.
- FFT_MAG_LOG_EN defined, sum=1 -> 0. sum=2^10 -> upper field 10, fraction 0. Latency is 5 cycles with RAM_LAT=2.
